// File: rtl/dmem_pkg.sv
// dmem_pkg -- shared definitions for the data-memory controller.
//   state_t         : controller FSM states (IDLE, ACCESS, DONE)
//   BE_WORD         : byte-lane enables for a full 32-bit access
//   TIMEOUT_DEFAULT : default number of ACCESS cycles allowed before a fault
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [3:0] BE_WORD         = 4'b1111;
  localparam int         TIMEOUT_DEFAULT = 15;

endpackage

// File: rtl/dmem_lane.sv
// dmem_lane -- combinational byte-lane steering for dmem_ctrl.
// Write side (driven from the request as it is accepted):
//   wr_byte  in  : byte store/load selected
//   wr_off   in  : address bits [1:0] of the request
//   wr_data  in  : store data from the datapath
//   wr_be    out : lane enables (BE_WORD for words, one-hot for bytes)
//   wr_lanes out : bus write data (byte replicated onto all lanes for bytes)
// Read side (driven from the registered request while the bus answers):
//   rd_byte  in  : registered byte flag
//   rd_off   in  : registered address bits [1:0]
//   rd_data  in  : raw bus read data
//   rd_result out: load result (addressed lane zero-extended for bytes)
module dmem_lane
  import dmem_pkg::*;
(
  input  logic        wr_byte,
  input  logic [1:0]  wr_off,
  input  logic [31:0] wr_data,
  output logic [3:0]  wr_be,
  output logic [31:0] wr_lanes,
  input  logic        rd_byte,
  input  logic [1:0]  rd_off,
  input  logic [31:0] rd_data,
  output logic [31:0] rd_result
);

  logic [7:0] rd_lane [4];

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign rd_lane[gi] = rd_data[8*gi +: 8];
  end

  always_comb begin
    wr_be     = BE_WORD;
    wr_lanes  = wr_data;
    rd_result = rd_data;
    if (wr_byte) begin
      wr_be    = 4'b0001 << wr_off;
      wr_lanes = {4{wr_data[7:0]}};
    end
    if (rd_byte) begin
      rd_result = {24'h000000, rd_lane[rd_off]};
    end
  end

endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl -- data-memory access controller between the CPU datapath and a
// simple request/acknowledge bus.
// Optional feature: define DMEM_BYTE_ACCESS_EN to compile in byte accesses
// (ByteOp). Without it ByteOp is ignored and every access is a word access.
// Ports:
//   clk, reset (async, active-high)
//   MemWrite, MemRead, ByteOp, ALUResult, WriteData : request from the core
//   ReadData  : registered load result, held until the next load ends
//   Stall     : freezes PC/register write while an access is in flight
//   MemFault  : one-cycle pulse on misaligned or timed-out access
//   bus_req, bus_we, bus_addr, bus_wdata, bus_be : registered bus request
//   bus_ack, bus_rdata : bus completion and load data
// Parameter TIMEOUT: ACCESS cycles without bus_ack before the access faults.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic        ByteOp,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        MemFault,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam int             CW       = $clog2(TIMEOUT + 1);
  // The counter holds the number of ACCESS cycles already completed, so the
  // cycle that sees this value is the TIMEOUT-th one.
  localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [31:0]   rdata_reg, rdata_next;
  logic          fault_reg, fault_next;
  logic          req_reg, req_next;
  logic          we_reg, we_next;
  logic [31:0]   addr_reg, addr_next;
  logic [31:0]   wdata_reg, wdata_next;
  logic [3:0]    be_reg, be_next;
  logic [1:0]    off_reg, off_next;
  logic          byte_reg, byte_next;
  logic          stall_int;

  logic          byte_op;
  logic          misaligned;
  logic [3:0]    lane_be;
  logic [31:0]   lane_wdata;
  logic [31:0]   lane_rdata;

`ifdef DMEM_BYTE_ACCESS_EN
  assign byte_op = ByteOp;
`else
  logic unused_byte_op;
  assign unused_byte_op = ByteOp;
  assign byte_op        = 1'b0;
`endif

  assign misaligned = !byte_op && (ALUResult[1:0] != 2'b00);

  dmem_lane u_lane (
    .wr_byte   (byte_op),
    .wr_off    (ALUResult[1:0]),
    .wr_data   (WriteData),
    .wr_be     (lane_be),
    .wr_lanes  (lane_wdata),
    .rd_byte   (byte_reg),
    .rd_off    (off_reg),
    .rd_data   (bus_rdata),
    .rd_result (lane_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg   <= '0;
      rdata_reg <= '0;
      fault_reg <= 1'b0;
      req_reg   <= 1'b0;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      be_reg    <= '0;
      off_reg   <= '0;
      byte_reg  <= 1'b0;
    end else begin
      cnt_reg   <= cnt_next;
      rdata_reg <= rdata_next;
      fault_reg <= fault_next;
      req_reg   <= req_next;
      we_reg    <= we_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      be_reg    <= be_next;
      off_reg   <= off_next;
      byte_reg  <= byte_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    rdata_next = rdata_reg;
    fault_next = 1'b0;
    req_next   = req_reg;
    we_next    = we_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    be_next    = be_reg;
    off_next   = off_reg;
    byte_next  = byte_reg;
    stall_int  = 1'b0;

    unique case (state_reg)
      IDLE: begin
        if (MemRead || MemWrite) begin
          if (misaligned) begin
            // Rejected before touching the bus; the core is not stalled.
            fault_next = 1'b1;
            if (!MemWrite) begin
              rdata_next = '0;
            end
          end else begin
            stall_int  = 1'b1;
            req_next   = 1'b1;
            we_next    = MemWrite;  // read+write together is a store
            addr_next  = {ALUResult[31:2], 2'b00};
            wdata_next = lane_wdata;
            be_next    = lane_be;
            off_next   = ALUResult[1:0];
            byte_next  = byte_op;
            cnt_next   = '0;
            state_next = ACCESS;
          end
        end
      end

      ACCESS: begin
        stall_int = 1'b1;
        // Ack is tested first so it wins over a simultaneous timeout.
        if (bus_ack) begin
          req_next   = 1'b0;
          if (!we_reg) begin
            rdata_next = lane_rdata;
          end
          state_next = DONE;
        end else if (cnt_reg == CNT_LAST) begin
          req_next   = 1'b0;
          fault_next = 1'b1;
          if (!we_reg) begin
            rdata_next = '0;
          end
          state_next = DONE;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end

      DONE: begin
        // Release the core for one cycle; the request still on the inputs
        // belongs to the instruction that just finished.
        cnt_next   = '0;
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign Stall     = stall_int && !reset;
  assign ReadData  = rdata_reg;
  assign MemFault  = fault_reg;
  assign bus_req   = req_reg;
  assign bus_we    = we_reg;
  assign bus_addr  = addr_reg;
  assign bus_wdata = wdata_reg;
  assign bus_be    = be_reg;

endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15: cycles in ACCESS without bus_ack before a fault.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port MemWrite  input  1  store request from the controller.
REQ-005 SHALL have port MemRead  input  1  load request from the controller.
REQ-006 SHALL have port ByteOp  input  1  byte access (LDRB/STRB), ignored unless DMEM_BYTE_ACCESS_EN is defined.
REQ-007 SHALL have port ALUResult  input  32  effective address from the datapath.
REQ-008 SHALL have port WriteData  input  32  store data from the datapath.
REQ-009 SHALL have port ReadData  output  32  registered load data to the result mux.
REQ-010 SHALL have port Stall  output  1  holds PC and register write while high.
REQ-011 SHALL have port MemFault  output  1  one-cycle pulse on a misaligned or timed-out access.
REQ-012 SHALL have port bus_req  output  1  bus request.
REQ-013 SHALL have port bus_we  output  1  bus write enable.
REQ-014 SHALL have port bus_addr  output  32  word-aligned bus address (bits [1:0] = 0).
REQ-015 SHALL have port bus_wdata  output  32  bus write data.
REQ-016 SHALL have port bus_be  output  4  byte-lane enables.
REQ-017 SHALL have port bus_ack  input  1  access complete; bus_rdata valid for loads.
REQ-018 SHALL have port bus_rdata  input  32  bus read data.

Function
REQ-019 SHALL implement an FSM with states IDLE, ACCESS and DONE.
REQ-020 IDLE, request present (MemRead or MemWrite) and aligned: SHALL drive Stall=1 combinationally, register the address, data and op, and enter ACCESS.
REQ-021 SHALL treat MemRead=MemWrite=1 as a store.
REQ-022 Word access with ALUResult[1:0]!=0: SHALL start no bus cycle, pulse MemFault, keep Stall=0, set ReadData=0 on loads, and stay in IDLE.
REQ-023 ACCESS: SHALL hold bus_req=1 and all bus outputs stable until bus_ack; Stall=1 throughout.
REQ-024 bus_ack in ACCESS: SHALL capture the load result into ReadData, drop bus_req next cycle, and enter DONE.
REQ-025 Timeout counter reaching TIMEOUT in ACCESS with no ack: SHALL drop bus_req, pulse MemFault, set ReadData=0 on loads, and enter DONE.
REQ-026 bus_ack in the same cycle the counter reaches TIMEOUT: ack SHALL win and no fault is raised.
REQ-027 DONE: SHALL drive Stall=0 for exactly one cycle, ignore the still-asserted request, and always return to IDLE.
REQ-028 Minimum latency with ack in the first ACCESS cycle: Stall high 2 cycles, so a memory instruction takes 3 cycles.
REQ-029 Word access: bus_be SHALL be 4'b1111 and bus_wdata SHALL equal WriteData.
REQ-030 ReadData SHALL hold its value until the next load completes or faults.

Reset
REQ-031 reset SHALL asynchronously force IDLE, counter=0, ReadData=0, MemFault=0, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, bus_be=0.
REQ-032 Stall SHALL be 0 while reset is high.
REQ-033 Reset during ACCESS SHALL abandon the transfer with no fault pulse.

Configuration
REQ-034 SHALL use macro DMEM_BYTE_ACCESS_EN to compile in byte accesses.
REQ-035 With DMEM_BYTE_ACCESS_EN defined, byte access SHALL have no alignment fault.
REQ-036 With DMEM_BYTE_ACCESS_EN defined, byte access SHALL set bus_be = 1 << addr[1:0] and replicate WriteData[7:0] onto all four lanes.
REQ-037 With DMEM_BYTE_ACCESS_EN defined, byte load SHALL zero-extend the addressed lane into ReadData.
REQ-038 Without DMEM_BYTE_ACCESS_EN, ByteOp SHALL be ignored and every access SHALL be a word access.

Structure
REQ-039 Package dmem_pkg SHALL hold the state encoding, BE_WORD=4'b1111 and the default TIMEOUT.
REQ-040 Lane select/replicate/zero-extend SHALL be a combinational sub-module dmem_lane.

Verification
REQ-041 Bench SHALL cover: word load from 0x100, ack in 1st ACCESS cycle, bus_rdata=0xDEADBEEF -> Stall high 2 cycles, ReadData=0xDEADBEEF in DONE.
REQ-042 Bench SHALL cover: word store to 0x104 of 0x12345678, ack after 3 cycles -> bus_we=1, bus_be=1111, bus_addr=0x104 stable 3 cycles, Stall high 4 cycles.
REQ-043 Bench SHALL cover: word load from 0x102 -> no bus_req, MemFault pulse 1 cycle, ReadData=0, Stall=0.
REQ-044 Bench SHALL cover: load with no ack, TIMEOUT=15 -> bus_req high 15 cycles, then MemFault pulse and ReadData=0.
REQ-045 Bench SHALL cover: reset asserted in the 2nd ACCESS cycle -> bus_req=0 immediately, state IDLE, no MemFault.
REQ-046 Bench SHALL cover (DMEM_BYTE_ACCESS_EN defined): byte store 0xAB to 0x203 -> bus_be=1000, bus_wdata=0xABABABAB, bus_addr=0x200.
